// File: rtl/iexecute_pipe.sv
// Registered, handshaked execute stage: ALU, zero flag, branch target and an iterative shift-add MUL.
// Single-cycle ops complete at the accept edge; MUL completes WIDTH edges after accept.
module iexecute_pipe #(
    parameter int WIDTH      = 64,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cur_pc,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] sign_extended_output,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic             alu_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    function automatic void alu_eval(
        input  logic [1:0]              aop,
        input  logic [10:0]             opc,
        input  logic signed [WIDTH-1:0] a,
        input  logic signed [WIDTH-1:0] b,
        output logic signed [WIDTH-1:0] res,
        output logic                    ill,
        output logic                    is_mul
    );
        res    = '0;
        ill    = 1'b0;
        is_mul = 1'b0;
        case (aop)
            2'b00: res = a + b;
            2'b01: res = b;
            2'b10: begin
                case (opc)
                    OPC_ADD: res = a + b;
                    OPC_SUB: res = a - b;
                    OPC_AND: res = a & b;
                    OPC_ORR: res = a | b;
                    OPC_MUL: begin
                        if (MUL_ENABLE) is_mul = 1'b1;
                        else            ill    = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    endfunction

    logic [0:0]              state;
    logic [CNT_W-1:0]        mul_cnt;
    logic signed [WIDTH-1:0] mcand_p0;
    logic signed [WIDTH-1:0] mplier_p0;
    logic signed [WIDTH-1:0] acc_p0;
    logic signed [WIDTH-1:0] bt_p0;

    logic                    vld_p1;
    logic signed [WIDTH-1:0] res_p1;
    logic signed [WIDTH-1:0] bt_p1;
    logic                    zero_p1;
    logic                    ill_p1;

    logic signed [WIDTH-1:0] opa_s;
    logic signed [WIDTH-1:0] opb_s;
    logic signed [WIDTH-1:0] bt_in;
    logic signed [WIDTH-1:0] eval_res;
    logic                    eval_ill;
    logic                    eval_mul;
    logic signed [WIDTH-1:0] acc_next;
    logic                    out_free;
    logic                    accept;
    logic                    mul_last;
    logic                    mul_done;
    logic                    mul_step;

    assign opa_s = read_data1;
    assign opb_s = alu_src ? sign_extended_output : read_data2;
    assign bt_in = cur_pc + (sign_extended_output << 2);

    always_comb begin
        eval_res = '0;
        eval_ill = 1'b0;
        eval_mul = 1'b0;
        alu_eval(alu_op, opcode, opa_s, opb_s, eval_res, eval_ill, eval_mul);
    end

    assign out_free = !vld_p1 || out_ready;
    assign in_ready = reset_n && (state == ST_IDLE) && out_free && !flush;
    assign accept   = in_valid && in_ready;

    // A finished MUL waits on its last iteration until the output register can take it
    assign mul_last = (state == ST_MUL) && (mul_cnt == CNT_ONE);
    assign mul_done = mul_last && out_free;
    assign mul_step = (state == ST_MUL) && !(mul_last && !out_free);
    assign acc_next = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;

    // Stage p0: multiplier operand capture and shift-add iteration
    always_ff @(posedge clk) begin
        if (accept && eval_mul) begin
            mcand_p0  <= opa_s;
            mplier_p0 <= opb_s;
            acc_p0    <= '0;
            bt_p0     <= bt_in;
        end else if (mul_step) begin
            acc_p0    <= acc_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    // Stage p1: sequencing and the EX/MEM-facing output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            bt_p1   <= '0;
            zero_p1 <= 1'b0;
            ill_p1  <= 1'b0;
        end else if (flush) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (accept && eval_mul) begin
                state   <= ST_MUL;
                mul_cnt <= CNT_INIT;
            end else if (mul_done) begin
                state   <= ST_IDLE;
                mul_cnt <= '0;
            end else if (mul_step) begin
                mul_cnt <= mul_cnt - CNT_ONE;
            end

            if (accept && !eval_mul) begin
                vld_p1  <= 1'b1;
                res_p1  <= eval_res;
                bt_p1   <= bt_in;
                zero_p1 <= (eval_res == '0);
                ill_p1  <= eval_ill;
            end else if (mul_done) begin
                vld_p1  <= 1'b1;
                res_p1  <= acc_next;
                bt_p1   <= bt_p0;
                zero_p1 <= (acc_next == '0);
                ill_p1  <= 1'b0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign alu_result    = res_p1;
    assign branch_target = bt_p1;
    assign zero          = zero_p1;
    assign illegal       = ill_p1;

endmodule

// File: tb/tb_iexecute_pipe.sv
// Directed bench for iexecute_pipe: scoreboard of expected results pushed on accept,
// popped and compared on each output transfer, plus spot checks at key points.
module tb_iexecute_pipe;

    localparam int W = 64;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;
    localparam logic [10:0] OPC_BAD = 11'b11111111111;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] cur_pc;
    logic [W-1:0] read_data1;
    logic [W-1:0] read_data2;
    logic [W-1:0] sign_extended_output;
    logic [1:0]   alu_op;
    logic [10:0]  opcode;
    logic         alu_src;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] branch_target;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zf;
        logic         ill;
        logic [W-1:0] bt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    iexecute_pipe #(.WIDTH(W), .MUL_ENABLE(1'b1)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .cur_pc               (cur_pc),
        .read_data1           (read_data1),
        .read_data2           (read_data2),
        .sign_extended_output (sign_extended_output),
        .alu_op               (alu_op),
        .opcode               (opcode),
        .alu_src              (alu_src),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .branch_target        (branch_target),
        .alu_result           (alu_result),
        .zero                 (zero),
        .illegal              (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] imm, input logic [W-1:0] pc,
                                   input logic [1:0] aop, input logic [10:0] opc,
                                   input logic src);
        exp_t         e;
        logic [W-1:0] bb;
        bb    = src ? imm : b;
        e.res = '0;
        e.ill = 1'b0;
        e.bt  = pc + imm * 4;
        if (aop == 2'b00)      e.res = a + bb;
        else if (aop == 2'b01) e.res = bb;
        else if (aop == 2'b10) begin
            if (opc == OPC_ADD)      e.res = a + bb;
            else if (opc == OPC_SUB) e.res = a - bb;
            else if (opc == OPC_AND) e.res = a & bb;
            else if (opc == OPC_ORR) e.res = a | bb;
            else if (opc == OPC_MUL) e.res = a * bb;
            else                     e.ill = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        e.zf = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic service();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_has_entry", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result",  alu_result,    e.res);
                chk("sb_zero",    W'(zero),      W'(e.zf));
                chk("sb_illegal", W'(illegal),   W'(e.ill));
                chk("sb_target",  branch_target, e.bt);
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1)
            sb.push_back(model(read_data1, read_data2, sign_extended_output, cur_pc,
                               alu_op, opcode, alu_src));
    endtask

    task automatic tick();
        #1;
        service();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [W-1:0] pc,
                          input logic [1:0] aop, input logic [10:0] opc, input logic src);
        read_data1           = a;
        read_data2           = b;
        sign_extended_output = imm;
        cur_pc               = pc;
        alu_op               = aop;
        opcode               = opc;
        alu_src              = src;
    endtask

    task automatic send();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        for (int i = 0; i < budget && out_valid !== 1'b1; i++) tick();
        chk("wait_out", W'(out_valid), W'(1));
    endtask

    initial begin
        int bad;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op('0, '0, '0, '0, 2'b00, 11'd0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result",    alu_result,    W'(0));
        chk("rst_target",    branch_target, W'(0));
        chk("rst_zero",      W'(zero),      W'(0));
        chk("rst_illegal",   W'(illegal),   W'(0));
        chk("rst_in_ready",  W'(in_ready),  W'(0));
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", W'(in_ready),  W'(1));

        // ADD register form, latency 1
        set_op(64'd5, 64'd7, 64'h10, 64'h40, 2'b10, OPC_ADD, 1'b0);
        send();
        chk("add_valid",  W'(out_valid), W'(1));
        chk("add_result", alu_result,    W'(12));
        chk("add_zero",   W'(zero),      W'(0));

        // SUB to zero, CBZ pass-B, branch targets with negative offset and wrap
        set_op(64'd9, 64'd9, 64'd0, 64'd0, 2'b10, OPC_SUB, 1'b0);
        send();
        chk("sub_result", alu_result, W'(0));
        chk("sub_zero",   W'(zero),   W'(1));
        set_op(64'd0, 64'd0, -64'sd2, 64'h100, 2'b01, 11'd0, 1'b0);
        send();
        chk("cbz_zero",   W'(zero),      W'(1));
        chk("cbz_target", branch_target, 64'hF8);
        set_op(64'd1, 64'd99, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 11'd0, 1'b1);
        send();
        chk("wrap_target", branch_target, W'(0));
        chk("imm_result",  alu_result,    W'(2));
        set_op(64'hF0F0, 64'hFF00, 64'd3, 64'h200, 2'b10, OPC_AND, 1'b0);
        send();
        set_op(64'hF0F0, 64'h0F0F, 64'd4, 64'h300, 2'b10, OPC_ORR, 1'b0);
        send();
        chk("orr_result", alu_result, 64'hFFFF);

        // Iterative MUL: busy for WIDTH cycles, result at edge WIDTH
        set_op(64'hFFFF_FFFF, 64'd3, 64'd5, 64'h1000, 2'b10, OPC_MUL, 1'b0);
        send();
        bad = 0;
        for (int k = 1; k < W; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        chk("mul_busy_cycles", W'(bad), W'(0));
        tick();
        chk("mul_valid",   W'(out_valid), W'(1));
        chk("mul_result",  alu_result,    64'h2_FFFF_FFFD);
        chk("mul_target",  branch_target, 64'h1014);
        chk("mul_ready",   W'(in_ready),  W'(1));
        set_op(-64'sd1, -64'sd1, 64'd0, 64'h2000, 2'b10, OPC_MUL, 1'b0);
        send();
        wait_out(W + 8);
        chk("mul_neg_result", alu_result, W'(1));
        tick();

        // Back-pressure: result held, second op refused, then drain+accept on one edge
        out_ready = 1'b0;
        set_op(64'd100, 64'd23, 64'd0, 64'h400, 2'b10, OPC_ADD, 1'b0);
        send();
        set_op(64'd50, 64'd0, 64'd8, 64'h500, 2'b10, OPC_SUB, 1'b1);
        in_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", W'(in_ready),  W'(0));
            chk("bp_valid",    W'(out_valid), W'(1));
            chk("bp_result",   alu_result,    W'(123));
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_accept_valid",  W'(out_valid), W'(1));
        chk("bp_accept_result", alu_result,    W'(42));
        tick();
        chk("drain_valid", W'(out_valid), W'(0));

        // Flush in the middle of a MUL
        set_op(64'd7, 64'd6, 64'd0, 64'h600, 2'b10, OPC_MUL, 1'b0);
        send();
        for (int k = 0; k < 9; k++) tick();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", W'(in_ready), W'(0));
        sb.delete();
        tick();
        flush = 1'b0;
        #1;
        chk("post_flush_valid", W'(out_valid), W'(0));
        chk("post_flush_ready", W'(in_ready),  W'(1));
        bad = 0;
        for (int k = 0; k < W + 6; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        chk("flush_no_result", W'(bad), W'(0));
        set_op(64'd1, 64'd2, 64'd0, 64'h700, 2'b10, OPC_ADD, 1'b0);
        send();
        chk("post_flush_add", alu_result, W'(3));

        // Reset in the middle of a MUL, then illegal encodings
        set_op(64'd3, 64'd4, 64'd0, 64'h800, 2'b10, OPC_MUL, 1'b0);
        send();
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        sb.delete();
        tick();
        chk("rst2_in_ready", W'(in_ready),    W'(0));
        chk("rst2_valid",    W'(out_valid),   W'(0));
        chk("rst2_result",   alu_result,      W'(0));
        chk("rst2_target",   branch_target,   W'(0));
        chk("rst2_zero",     W'(zero),        W'(0));
        reset_n = 1'b1;
        tick();
        set_op(64'd5, 64'd6, 64'd1, 64'h900, 2'b10, OPC_BAD, 1'b0);
        send();
        chk("bad_opc_illegal", W'(illegal), W'(1));
        chk("bad_opc_result",  alu_result,  W'(0));
        chk("bad_opc_zero",    W'(zero),    W'(1));
        set_op(64'd5, 64'd6, 64'd1, 64'hA00, 2'b11, OPC_ADD, 1'b0);
        send();
        chk("aop11_illegal", W'(illegal), W'(1));
        chk("aop11_result",  alu_result,  W'(0));
        set_op(64'd20, 64'd22, 64'd1, 64'hB00, 2'b10, OPC_ADD, 1'b0);
        send();
        chk("legal_after_illegal", W'(illegal), W'(0));

        tick();
        tick();
        tick();
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
